ufm_spi_responder: RTL and testbench

UFM_SPI_RESPONDER -- requirements
Module: ufm_spi_responder

---
 rtl/ufm_spi_responder.sv | 193 +++++++++++++++++++
 tb/tb_ufm_spi_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_spi_responder.sv
// SPI mode-0 responder mapping opcode/address/data commands onto a word-wide memory port.
// Inputs see a 2-flop resync; reads return one clock after mem_rd; no backpressure, sck paces all traffic.
module ufm_spi_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  ncs,
  input  logic                  si,
  output logic                  so,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cmd_err,
  output logic                  wel
);

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, READ, WRITE, STATUS, IGNORE} state_t;

  localparam logic [4:0]            LAST_BIT = 5'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [1:0] sck_sync, ncs_sync, si_sync;
  logic       sck_prev;
  logic       sck_rise, sck_fall, ncs_q, si_q;

  state_t                state;
  logic                  armed;
  logic                  is_write;
  logic [4:0]            bit_cnt;
  logic [6:0]            op_sr;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] pf_buf;
  logic                  rd_to_sr, rd_to_pf, ld_sr, ld_pf;
  logic [7:0]            opcode;
  logic [7:0]            status_byte;
  logic [DATA_WIDTH-1:0] word_in;

  always_ff @(posedge clock) begin
    sck_sync <= {sck_sync[0], sck};
    ncs_sync <= {ncs_sync[0], ncs};
    si_sync  <= {si_sync[0], si};
    sck_prev <= sck_sync[1];
  end

  assign ncs_q       = ncs_sync[1];
  assign si_q        = si_sync[1];
  assign sck_rise    = sck_sync[1] & ~sck_prev;
  assign sck_fall    = ~sck_sync[1] & sck_prev;
  assign opcode      = {op_sr, si_q};
  assign word_in     = {sr[DATA_WIDTH-2:0], si_q};
  assign status_byte = {6'b0, wel, 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      is_write  <= 1'b0;
      bit_cnt   <= '0;
      op_sr     <= '0;
      sr        <= '0;
      pf_buf    <= '0;
      rd_to_sr  <= 1'b0;
      rd_to_pf  <= 1'b0;
      ld_sr     <= 1'b0;
      ld_pf     <= 1'b0;
      so        <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      cmd_err   <= 1'b0;
      wel       <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      cmd_err  <= 1'b0;
      rd_to_sr <= 1'b0;
      rd_to_pf <= 1'b0;
      // Read data lands one clock after the strobe, so the load flag trails mem_rd by a cycle.
      ld_sr    <= rd_to_sr;
      ld_pf    <= rd_to_pf;
      if (ld_sr) sr <= mem_rdata;
      if (ld_pf) pf_buf <= mem_rdata;
      if (mem_wr) mem_addr <= mem_addr + ADDR_ONE;

      if (state != IDLE && ncs_q) begin
        state    <= IDLE;
        armed    <= 1'b1;
        bit_cnt  <= '0;
        op_sr    <= '0;
        sr       <= '0;
        so       <= 1'b0;
        ld_sr    <= 1'b0;
        ld_pf    <= 1'b0;
        is_write <= 1'b0;
        if (is_write) wel <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            so <= 1'b0;
            // Only a high-to-low ncs seen from IDLE starts a command, so a reset inside a frame waits it out.
            if (ncs_q) begin
              armed <= 1'b1;
            end else if (armed) begin
              armed   <= 1'b0;
              bit_cnt <= '0;
              state   <= OPCODE;
            end
          end
          OPCODE: if (sck_rise) begin
            op_sr   <= opcode[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              case (opcode)
                8'h03: state <= ADDR;
                8'h02: begin
                  is_write <= 1'b1;
                  state    <= ADDR;
                end
                8'h06: begin
                  wel   <= 1'b1;
                  state <= IGNORE;
                end
                8'h04: begin
                  wel   <= 1'b0;
                  state <= IGNORE;
                end
                8'h05: state <= STATUS;
                default: begin
                  cmd_err <= 1'b1;
                  state   <= IGNORE;
                end
              endcase
            end
          end
          ADDR: if (sck_rise) begin
            // Shifting through an ADDR_WIDTH register drops the unused upper address bits for free.
            mem_addr <= {mem_addr[ADDR_WIDTH-2:0], si_q};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              bit_cnt <= '0;
              if (is_write) begin
                state <= WRITE;
              end else begin
                mem_rd   <= 1'b1;
                rd_to_sr <= 1'b1;
                state    <= READ;
              end
            end
          end
          READ: if (sck_fall) begin
            so      <= sr[DATA_WIDTH-1];
            sr      <= {sr[DATA_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd0) begin
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + ADDR_ONE;
              rd_to_pf <= 1'b1;
            end
            if (bit_cnt == LAST_BIT) begin
              sr      <= pf_buf;
              bit_cnt <= '0;
            end
          end
          WRITE: if (sck_rise) begin
            sr      <= word_in;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (wel) begin
                mem_wr    <= 1'b1;
                mem_wdata <= word_in;
              end
            end
          end
          STATUS: if (sck_fall) begin
            so      <= status_byte[~bit_cnt[2:0]];
            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
          end
          IGNORE: so <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ufm_spi_responder.sv
// Drives SPI frames from the initiator side and checks serial data, memory strobes and flags against a memory model.
`timescale 1ns/1ps
module tb_ufm_spi_responder;
  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int HALF = 7;

  logic          clock = 1'b0;
  logic          reset, sck, ncs, si, so, mem_rd, mem_wr, cmd_err, wel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, mem_wdata;

  always #5 clock = ~clock;

  ufm_spi_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .sck(sck), .ncs(ncs), .si(si), .so(so),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .cmd_err(cmd_err), .wel(wel)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  logic [DW-1:0] wdata_q[$];
  logic          tx_q[$];
  logic          rx_q[$];
  int            overlap_cnt = 0;
  int            err_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          wel_model;

  always @(posedge clock) begin
    if (mem_rd) begin
      rd_log.push_back(mem_addr);
      mem_rdata <= mem[mem_addr];
    end
    if (mem_wr) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
    if (mem_rd && mem_wr) overlap_cnt++;
    if (cmd_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    err_cnt = 0;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
  endtask

  task automatic spi_begin();
    ncs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    ncs = 1'b1;
    wait_clk(HALF);
    sck = 1'b0;
    wait_clk(HALF);
  endtask

  // Initiator samples so just before each rise; the final rise of a frame may keep sck high.
  task automatic spi_run(input bit last_fall);
    rx_q.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      si = tx_q[i];
      wait_clk(HALF);
      rx_q.push_back(so);
      sck = 1'b1;
      wait_clk(HALF);
      if (last_fall || i != tx_q.size() - 1) sck = 1'b0;
    end
    tx_q.delete();
  endtask

  function automatic logic [31:0] rx_field(input int start, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], rx_q[start + i]};
    return v;
  endfunction

  task automatic do_read(input string tag, input logic [AW-1:0] addr, input int nwords);
    logic [AW-1:0] a;
    clear_logs();
    push_bits(32'h03, 8);
    push_bits({7'($urandom), addr}, 16);
    for (int i = 0; i < nwords * DW; i++) tx_q.push_back(1'($urandom));
    spi_begin();
    spi_run(1'b0);
    spi_end();
    for (int w = 0; w < nwords; w++) begin
      a = addr + AW'(w);
      check({tag, "_data"}, rx_field(24 + w * DW, DW), mem[a]);
    end
    check({tag, "_hdr_so"}, rx_field(0, 24), 0);
    check({tag, "_nrd"}, rd_log.size(), nwords + 1);
    for (int w = 0; w <= nwords && w < rd_log.size(); w++) begin
      a = addr + AW'(w);
      check({tag, "_rdaddr"}, rd_log[w], a);
    end
    check({tag, "_nwr"}, wr_addr_log.size(), 0);
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] addr, input int nwords, input int extra_bits);
    logic [DW-1:0] data[$];
    logic [AW-1:0] a;
    clear_logs();
    push_bits(32'h02, 8);
    push_bits({7'($urandom), addr}, 16);
    for (int w = 0; w < nwords; w++) begin
      data.push_back((w < wdata_q.size()) ? wdata_q[w] : DW'($urandom));
      push_bits(data[w], DW);
    end
    for (int i = 0; i < extra_bits; i++) tx_q.push_back(1'($urandom));
    wdata_q.delete();
    spi_begin();
    spi_run(1'b0);
    spi_end();
    if (wel_model) begin
      check({tag, "_nwr"}, wr_addr_log.size(), nwords);
      for (int w = 0; w < nwords; w++) begin
        a = addr + AW'(w);
        mem[a] = data[w];
        if (w < wr_addr_log.size()) begin
          check({tag, "_wraddr"}, wr_addr_log[w], a);
          check({tag, "_wrdata"}, wr_data_log[w], data[w]);
        end
      end
    end else begin
      check({tag, "_nwr_prot"}, wr_addr_log.size(), 0);
    end
    wel_model = 1'b0;
    check({tag, "_wel"}, wel, wel_model);
    check({tag, "_nrd"}, rd_log.size(), 0);
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] op, input int nbytes);
    logic [7:0] exp_byte;
    bit         known;
    clear_logs();
    push_bits(op, 8);
    for (int i = 0; i < nbytes * 8; i++) tx_q.push_back(1'($urandom));
    spi_begin();
    spi_run(1'b0);
    spi_end();
    known    = (op == 8'h04 || op == 8'h05 || op == 8'h06);
    exp_byte = (op == 8'h05) ? {6'b0, wel_model, 1'b0} : 8'h00;
    if (op == 8'h06) wel_model = 1'b1;
    else if (op == 8'h04) wel_model = 1'b0;
    check({tag, "_op_so"}, rx_field(0, 8), 0);
    for (int b = 0; b < nbytes; b++) check({tag, "_so_byte"}, rx_field(8 + 8 * b, 8), exp_byte);
    check({tag, "_cmd_err"}, err_cnt, known ? 0 : 1);
    check({tag, "_wel"}, wel, wel_model);
    check({tag, "_mem_traffic"}, rd_log.size() + wr_addr_log.size(), 0);
  endtask

  initial begin
    logic [7:0]    op;
    logic [AW-1:0] addr;
    wel_model = 1'b0;
    sck   = 1'b0;
    ncs   = 1'b1;
    si    = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    wait_clk(3);
    check("reset_outs", {so, mem_rd, mem_wr, cmd_err, wel, mem_addr, mem_wdata}, 0);
    reset = 1'b0;
    wait_clk(4);

    mem[5] = 16'hA5C3;
    mem[6] = 16'h1234;
    do_read("rd_basic", 9'h005, 2);
    mem[9'h1FF] = 16'hFFFF;
    mem[9'h000] = 16'h0001;
    do_read("rd_wrap", 9'h1FF, 2);

    do_cmd("wren", 8'h06, 0);
    wdata_q = '{16'hBEEF, 16'hCAFE};
    do_write("wr_basic", 9'h010, 2, 0);
    do_read("wr_readback", 9'h010, 2);

    wdata_q = '{16'h1111};
    do_write("wr_prot", 9'h020, 1, 0);
    do_cmd("status_wel0", 8'h05, 2);
    do_cmd("wren2", 8'h06, 0);
    do_cmd("status_wel1", 8'h05, 2);
    do_cmd("wrdis", 8'h04, 0);
    do_read("prot_readback", 9'h020, 1);

    do_cmd("wren3", 8'h06, 0);
    do_write("wr_abort", 9'h030, 0, 10);
    do_cmd("bad_op", 8'h9F, 2);

    for (int k = 0; k < 2; k++) begin
      logic seq[$];
      int   nb;
      int   ones;
      nb = (k == 0) ? 20 : 30;
      push_bits(32'h03, 8);
      push_bits(32'h0005, 16);
      for (int i = 0; i < 2 * DW; i++) tx_q.push_back(1'($urandom));
      seq = tx_q;
      tx_q.delete();
      for (int i = 0; i < nb; i++) tx_q.push_back(seq[i]);
      spi_begin();
      spi_run(1'b1);
      reset = 1'b1;
      wait_clk(1);
      check("midrst_outs", {so, mem_rd, mem_wr, cmd_err, wel, mem_addr, mem_wdata}, 0);
      reset = 1'b0;
      wel_model = 1'b0;
      clear_logs();
      for (int i = nb; i < seq.size(); i++) tx_q.push_back(seq[i]);
      spi_run(1'b0);
      spi_end();
      ones = 0;
      foreach (rx_q[i]) if (rx_q[i]) ones++;
      check("midrst_so", ones, 0);
      check("midrst_nrd", rd_log.size() + wr_addr_log.size(), 0);
      do_read("post_rst_read", AW'($urandom), 1);
    end

    for (int it = 0; it < 12; it++) begin
      addr = AW'($urandom);
      case ($urandom_range(0, 3))
        0: do_read("rnd_read", addr, $urandom_range(1, 3));
        1: begin
          if ($urandom_range(0, 1) == 1) do_cmd("rnd_wren", 8'h06, 0);
          do_write("rnd_write", addr, $urandom_range(1, 2),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0);
          do_read("rnd_readback", addr, 2);
        end
        2: begin
          do_cmd("rnd_wel", ($urandom_range(0, 1) == 1) ? 8'h06 : 8'h04, 0);
          do_cmd("rnd_status", 8'h05, $urandom_range(1, 2));
        end
        default: begin
          op = 8'($urandom);
          if (op >= 8'h02 && op <= 8'h06) op = op ^ 8'h80;
          do_cmd("rnd_bad_op", op, 1);
        end
      endcase
    end

    check("rd_wr_overlap", overlap_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
